// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types, defaults and latency helper for the scan loader
//
// Purpose: common definitions for the control scan-chain master.
//   scan_state_t  : FSM state encoding
//   SCAN_WIDTH_DEF: default chain length
//   SCAN_DIV_DEF  : default CLK cycles per SCAN_CLK half-period / load phase
//   scan_latency  : CLK edges from an accepted request to the next possible accept
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD_HI,
    LOAD_GUARD,
    DONE
  } scan_state_t;

  localparam int SCAN_WIDTH_DEF = 5;
  localparam int SCAN_DIV_DEF   = 4;

  // WIDTH bit periods of 2*DIV, load and guard phases of DIV each,
  // one DONE cycle and one IDLE cycle before the next handshake.
  function automatic int scan_latency(input int width, input int div);
    return (2 * width + 2) * div + 2;
  endfunction

endpackage

// File: rtl/scan_phase_timer.sv
// rtl/scan_phase_timer.sv - DIV-cycle down-counter shared by every timed state
//
// Purpose: measures one phase of DIV CLK cycles.
//   i_clk    : system clock
//   i_reset  : asynchronous active-high reset
//   i_start  : reload for a fresh phase (asserted on the edge entering a state)
//   o_expire : high in the last cycle of the phase
module scan_phase_timer #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  output logic o_expire
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/scan_ctrl_loader.sv
// rtl/scan_ctrl_loader.sv - serial scan-chain master for the control path
//
// Purpose: accepts a control word over valid/ready, shifts it MSB first onto
// the control scan chain with generated SCAN_CLK pulses, pulses SCAN_LOAD and
// returns the previous chain contents captured from SCAN_OUT.
//   CLK, RESET          : system clock, asynchronous active-high reset
//   WR_DATA/WR_VALID/WR_READY : host request handshake
//   SCAN_CLK/SCAN_DATA/SCAN_LOAD : chain shift clock, serial data, latch pulse
//   SCAN_OUT            : serial return from the last chain stage
//   RD_DATA/RD_VALID    : captured previous contents, one-cycle valid
//   BUSY                : inverse of WR_READY
module scan_ctrl_loader
  import scan_pkg::*;
#(
  parameter int WIDTH = SCAN_WIDTH_DEF,
  parameter int DIV   = SCAN_DIV_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             WR_VALID,
  output logic             WR_READY,
  output logic             SCAN_CLK,
  output logic             SCAN_DATA,
  output logic             SCAN_LOAD,
  input  logic             SCAN_OUT,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic             BUSY
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  scan_state_t      r_state;
  scan_state_t      w_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_rd_data;
  logic [BW-1:0]    r_bit;
  logic             r_scan_clk;
  logic             r_scan_load;
  logic             r_rd_valid;
  logic             w_start;
  logic             w_expire;

  scan_phase_timer #(.DIV(DIV)) u_timer (
    .i_clk    (CLK),
    .i_reset  (RESET),
    .i_start  (w_start),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (WR_VALID) w_next = SHIFT_LO;
      SHIFT_LO:   if (w_expire) w_next = SHIFT_HI;
      SHIFT_HI:   if (w_expire) w_next = (r_bit == '0) ? LOAD_HI : SHIFT_LO;
      LOAD_HI:    if (w_expire) w_next = LOAD_GUARD;
      LOAD_GUARD: if (w_expire) w_next = DONE;
      DONE:       w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  // Every state change starts a new phase; DONE and IDLE ignore the timer.
  assign w_start = (w_next != r_state);

  // SCAN_CLK, SCAN_LOAD and RD_VALID are decoded from the next state and
  // registered so they are glitch-free and clear asynchronously on RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_scan_clk  <= 1'b0;
      r_scan_load <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_scan_clk  <= (w_next == SHIFT_HI);
      r_scan_load <= (w_next == LOAD_HI);
      r_rd_valid  <= (w_next == DONE);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_shift   <= '0;
      r_cap     <= '0;
      r_rd_data <= '0;
      r_bit     <= '0;
    end else begin
      if (r_state == IDLE && WR_VALID) begin
        r_shift <= WR_DATA;
        r_bit   <= BW'(WIDTH - 1);
      end
      // Sample the return just before SCAN_CLK rises, while the chain is stable.
      if (r_state == SHIFT_LO && w_expire) begin
        r_cap <= {r_cap[WIDTH-2:0], SCAN_OUT};
      end
      // Advance data on the falling SCAN_CLK so it never moves while SCAN_CLK=1.
      if (r_state == SHIFT_HI && w_expire) begin
        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
        if (r_bit != '0) begin
          r_bit <= r_bit - BW'(1);
        end
      end
      if (w_next == DONE) begin
        r_rd_data <= r_cap;
      end
    end
  end

  assign SCAN_DATA = (r_state == SHIFT_LO || r_state == SHIFT_HI) ? r_shift[WIDTH-1] : 1'b0;
  assign SCAN_CLK  = r_scan_clk;
  assign SCAN_LOAD = r_scan_load;
  assign RD_DATA   = r_rd_data;
  assign RD_VALID  = r_rd_valid;
  assign WR_READY  = (r_state == IDLE);
  assign BUSY      = ~WR_READY;

endmodule

// File: tb/tb_scan_ctrl_loader.sv
// tb/tb_scan_ctrl_loader.sv - scoreboard bench for scan_ctrl_loader
module tb_scan_ctrl_loader;

  logic        clk;
  logic        rst;
  logic [4:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        scan_clk;
  logic        scan_data;
  logic        scan_load;
  logic        scan_out;
  logic [4:0]  rd_data;
  logic        rd_valid;
  logic        busy;

  logic [11:0] b_wr_data;
  logic        b_wr_valid;
  logic        b_wr_ready;
  logic        b_scan_clk;
  logic        b_scan_data;
  logic        b_scan_load;
  logic        b_scan_out;
  logic [11:0] b_rd_data;
  logic        b_rd_valid;
  logic        b_busy;

  int n_vec  = 0;
  int n_miss = 0;

  scan_ctrl_loader u_dut (
    .CLK       (clk),
    .RESET     (rst),
    .WR_DATA   (wr_data),
    .WR_VALID  (wr_valid),
    .WR_READY  (wr_ready),
    .SCAN_CLK  (scan_clk),
    .SCAN_DATA (scan_data),
    .SCAN_LOAD (scan_load),
    .SCAN_OUT  (scan_out),
    .RD_DATA   (rd_data),
    .RD_VALID  (rd_valid),
    .BUSY      (busy)
  );

  scan_ctrl_loader #(.WIDTH(12), .DIV(2)) u_dut_b (
    .CLK       (clk),
    .RESET     (rst),
    .WR_DATA   (b_wr_data),
    .WR_VALID  (b_wr_valid),
    .WR_READY  (b_wr_ready),
    .SCAN_CLK  (b_scan_clk),
    .SCAN_DATA (b_scan_data),
    .SCAN_LOAD (b_scan_load),
    .SCAN_OUT  (b_scan_out),
    .RD_DATA   (b_rd_data),
    .RD_VALID  (b_rd_valid),
    .BUSY      (b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Loopback models of the chains and the control latches.
  logic [4:0]  chain_a = '0;
  logic [4:0]  latch_a = '0;
  logic [11:0] chain_b = '0;
  always @(posedge scan_clk)   chain_a <= {chain_a[3:0], scan_data};
  always @(posedge scan_load)  latch_a <= chain_a;
  always @(posedge b_scan_clk) chain_b <= {chain_b[10:0], b_scan_data};
  assign scan_out   = chain_a[4];
  assign b_scan_out = chain_b[11];

  // Handshake tracking and scoreboard push.
  int          edge_n    = 0;
  int          hs_edge   = -100000;
  int          b_hs_edge = -100000;
  int          b_hs_n    = 0;
  int          hs_list[$];
  logic [4:0]  sb_a[$];
  logic [11:0] sb_b[$];

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (wr_valid && wr_ready) begin
      hs_edge <= edge_n + 1;
      hs_list.push_back(edge_n + 1);
      sb_a.push_back(chain_a);
    end
    if (b_wr_valid && b_wr_ready) begin
      b_hs_edge <= edge_n + 1;
      b_hs_n    <= b_hs_n + 1;
      sb_b.push_back(chain_b);
    end
  end

  int cyc_a;
  int cyc_b;
  assign cyc_a = edge_n - hs_edge + 1;
  assign cyc_b = edge_n - b_hs_edge + 1;

  int          n_rise, load_cnt, load_first, load_last, rdv_cyc;
  int          rdv_cnt = 0, ovl = 0, stab_err = 0, busy_err = 0, ready_err = 0;
  int          rise_cyc[$];
  logic [63:0] rise_bits;
  logic        prev_clk = 1'b0, prev_data = 1'b0, tx_active = 1'b0;

  always @(negedge clk) begin
    if (cyc_a == 1) begin
      n_rise     <= 0;
      rise_bits  <= '0;
      load_cnt   <= 0;
      load_first <= -1;
      load_last  <= -1;
      rdv_cyc    <= -1;
      rise_cyc.delete();
      tx_active  <= 1'b1;
    end else begin
      if (scan_clk && !prev_clk) begin
        n_rise    <= n_rise + 1;
        rise_bits <= {rise_bits[62:0], scan_data};
        rise_cyc.push_back(cyc_a);
      end
      if (scan_load) begin
        load_cnt <= load_cnt + 1;
        if (load_first < 0) load_first <= cyc_a;
        load_last <= cyc_a;
      end
      if (rst) tx_active <= 1'b0;
    end
    if (scan_clk && prev_clk && scan_data != prev_data) stab_err <= stab_err + 1;
    if (scan_clk && scan_load) ovl <= ovl + 1;
    if (busy == wr_ready) busy_err <= busy_err + 1;
    if (tx_active && wr_ready && !rst) ready_err <= ready_err + 1;
    if (rd_valid) begin
      rdv_cnt   <= rdv_cnt + 1;
      rdv_cyc   <= cyc_a;
      tx_active <= 1'b0;
      if (sb_a.size() > 0) chk("a_rd_data", rd_data, sb_a.pop_front());
      else chk("a_rd_unexpected", sb_a.size(), 1);
    end
    prev_clk  <= scan_clk;
    prev_data <= scan_data;
  end

  int   b_n_rise, b_rdv_cyc;
  int   b_rdv_cnt = 0, b_ovl = 0, b_stab = 0;
  int   b_rise_cyc[$];
  logic b_prev_clk = 1'b0, b_prev_data = 1'b0;

  always @(negedge clk) begin
    if (cyc_b == 1) begin
      b_n_rise  <= 0;
      b_rdv_cyc <= -1;
      b_rise_cyc.delete();
    end else if (b_scan_clk && !b_prev_clk) begin
      b_n_rise <= b_n_rise + 1;
      b_rise_cyc.push_back(cyc_b);
    end
    if (b_scan_clk && b_prev_clk && b_scan_data != b_prev_data) b_stab <= b_stab + 1;
    if (b_scan_clk && b_scan_load) b_ovl <= b_ovl + 1;
    if (b_rd_valid) begin
      b_rdv_cnt <= b_rdv_cnt + 1;
      b_rdv_cyc <= cyc_b;
      if (sb_b.size() > 0) chk("b_rd_data", b_rd_data, sb_b.pop_front());
      else chk("b_rd_unexpected", sb_b.size(), 1);
    end
    b_prev_clk  <= b_scan_clk;
    b_prev_data <= b_scan_data;
  end

  task automatic start_a(input logic [4:0] d);
    int h;
    int n;
    @(negedge clk);
    wr_data  = d;
    wr_valid = 1'b1;
    h = hs_list.size();
    n = 0;
    while (hs_list.size() == h && n < 100) begin
      @(negedge clk);
      n++;
    end
    wr_valid = 1'b0;
    chk("a_handshake", hs_list.size() - h, 1);
  endtask

  task automatic finish_a(input int r0);
    int n;
    n = 0;
    while (rdv_cnt == r0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("a_done", rdv_cnt - r0, 1);
  endtask

  task automatic run_b(input logic [11:0] d);
    int h;
    int r0;
    int n;
    @(negedge clk);
    b_wr_data  = d;
    b_wr_valid = 1'b1;
    h  = b_hs_n;
    r0 = b_rdv_cnt;
    n  = 0;
    while (b_hs_n == h && n < 100) begin
      @(negedge clk);
      n++;
    end
    b_wr_valid = 1'b0;
    n = 0;
    while (b_rdv_cnt == r0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("b_done", b_rdv_cnt - r0, 1);
    chk("b_rise_count", b_n_rise, 12);
    for (int i = 0; i < b_rise_cyc.size(); i++) chk($sformatf("b_rise_%0d", i), b_rise_cyc[i], 3 + 4 * i);
    chk("b_rd_valid_cycle", b_rdv_cyc, 53);
  endtask

  logic [4:0] first_bits;
  logic [4:0] lat0;
  int         r0, h0, n;
  bit         saved;

  initial begin
    rst        = 1'b1;
    wr_data    = '0;
    wr_valid   = 1'b0;
    b_wr_data  = '0;
    b_wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_scan_clk", scan_clk, 0);
    chk("rst_scan_data", scan_data, 0);
    chk("rst_scan_load", scan_load, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic transaction: bit order, load pulse, read-back timing.
    r0 = rdv_cnt;
    start_a(5'b10110);
    finish_a(r0);
    chk("t1_rise_count", n_rise, 5);
    chk("t1_rise_bits", rise_bits[4:0], 5'b10110);
    for (int i = 0; i < rise_cyc.size(); i++) chk($sformatf("t1_rise_%0d", i), rise_cyc[i], 5 + 8 * i);
    chk("t1_load_cnt", load_cnt, 4);
    chk("t1_load_first", load_first, 41);
    chk("t1_load_last", load_last, 44);
    chk("t1_rd_valid_cycle", rdv_cyc, 49);
    chk("t1_latch", latch_a, 5'b10110);
    chk("t1_ready_after", wr_ready, 1);

    // Loopback: the second word reads back the first.
    r0 = rdv_cnt;
    start_a(5'b01001);
    finish_a(r0);
    chk("t2_latch", latch_a, 5'b01001);
    chk("t2_rise_bits", rise_bits[4:0], 5'b01001);

    // WR_VALID held high; WR_DATA changes mid-transaction.
    h0    = hs_list.size();
    r0    = rdv_cnt;
    saved = 1'b0;
    @(negedge clk);
    wr_data  = 5'h1C;
    wr_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 10) wr_data = 5'h03;
      if (i == 30) wr_data = 5'h15;
      if (!saved && rdv_cnt != r0) begin
        first_bits = rise_bits[4:0];
        saved      = 1'b1;
      end
      if (hs_list.size() - h0 >= 2) begin
        wr_valid = 1'b0;
        break;
      end
    end
    chk("t3_hs_count", hs_list.size() - h0, 2);
    if (hs_list.size() - h0 >= 2) chk("t3_hs_spacing", hs_list[h0 + 1] - hs_list[h0], 50);
    chk("t3_first_saved", saved, 1);
    chk("t3_first_bits", first_bits, 5'h1C);
    finish_a(r0 + 1);
    chk("t3_second_bits", rise_bits[4:0], 5'h15);
    chk("t3_latch", latch_a, 5'h15);

    // Reset in the middle of a transaction, while SCAN_CLK is high.
    start_a(5'h0F);
    n = 0;
    while (cyc_a != 22 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_clk_before_rst", scan_clk, 1);
    r0   = rdv_cnt;
    lat0 = latch_a;
    #2;
    rst = 1'b1;
    #1;
    chk("t4_clk_async", scan_clk, 0);
    chk("t4_load_async", scan_load, 0);
    chk("t4_ready_async", wr_ready, 1);
    sb_a.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("t4_no_rd_valid", rdv_cnt - r0, 0);
    chk("t4_no_load", load_cnt, 0);
    chk("t4_latch_kept", latch_a, lat0);
    chk("t4_ready_after", wr_ready, 1);
    r0 = rdv_cnt;
    start_a(5'h12);
    finish_a(r0);
    chk("t4_next_bits", rise_bits[4:0], 5'h12);
    chk("t4_next_rd_cycle", rdv_cyc, 49);
    chk("t4_next_latch", latch_a, 5'h12);

    // WIDTH=12, DIV=2 instance with loopback read-back.
    run_b(12'hA5C);
    run_b(12'h3F0);

    chk("a_overlap", ovl, 0);
    chk("a_data_stable", stab_err, 0);
    chk("a_busy_inverse", busy_err, 0);
    chk("a_ready_low_in_tx", ready_err, 0);
    chk("b_overlap", b_ovl, 0);
    chk("b_data_stable", b_stab, 0);
    chk("a_sb_empty", sb_a.size(), 0);
    chk("b_sb_empty", sb_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
